// File: rtl/dm_responder_if.sv
// Request/response bus between an initiator and dm_responder.
// The initiator holds req until it sees the one-cycle ready strobe.
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data memory with a fixed-latency responder.
// A request is captured in IDLE, held for WAIT extra cycles, then answered
// with a one-cycle ready strobe. Storage is split into four byte lanes so
// byte-enabled stores need no read-modify-write.
module dm_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 2
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);

  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  // WAIT=0 never enters WAITING, so the load value is irrelevant there.
  localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t live, cap_q, cur;
  logic accept;
  logic enter_resp;
  logic [DEPTH_LOG2-1:0] idx;
  logic misal;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic [31:0] rdata_q;
  logic unused_addr_hi;

  // Pack the live bus fields, and pick the request the current cycle acts on:
  // with WAIT=0 the commit happens on the accepting edge, before the capture
  // register is loaded, so IDLE must look at the bus directly.
  always_comb begin
    live.we    = bus.we;
    live.addr  = bus.addr;
    live.wdata = bus.wdata;
    live.be    = bus.be;
    cur        = (state_q == IDLE) ? live : cap_q;
  end

  // Upper address bits alias onto the same words.
  assign idx            = cur.addr[DEPTH_LOG2+1:2];
  assign misal          = |cur.addr[1:0];
  assign unused_addr_hi = ^cur.addr[31:DEPTH_LOG2+2];

  // Next-state logic: accept in IDLE, count down in WAITING, one cycle of RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAITING;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAITING: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, wait counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) cap_q <= live;
    end
  end

  // One byte-wide memory per lane; misaligned stores are dropped.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic       wr;

    assign wr         = enter_resp & cur.we & ~misal & cur.be[i];
    assign rd_word[i] = mem[idx];

    // Byte lane write; reset wipes the whole lane.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
      end else if (wr) begin
        mem[idx] <= cur.wdata[8*i +: 8];
      end
    end
  end

  // Load data is registered on entry to RESP and held until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (enter_resp && !cur.we) begin
      rdata_q <= misal ? 32'd0 : rd_word;
    end
  end

  assign bus.ready = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.err   = (state_q == RESP) & (|cap_q.addr[1:0]);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a WAIT=2 instance exercised with directed
// and random traffic, plus a WAIT=0 instance driven with req held high.
module tb_dm_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;

  dm_responder_if bus();
  dm_responder_if bus0();

  dm_responder #(.DEPTH_LOG2(10), .WAIT(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  dm_responder #(.DEPTH_LOG2(10), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  logic [31:0] ref_mem  [1024];
  logic [31:0] ref_mem0 [1024];
  logic [31:0] last_rd, last_rd0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: a word array updated by the plain rules (byte merge on aligned
  // stores, zero data on misaligned loads, store responses keep old rdata).
  task automatic ref_apply(input bit i0, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
    int idx;
    logic [31:0] word, lr;
    idx   = int'(addr[11:2]);
    word  = i0 ? ref_mem0[idx] : ref_mem[idx];
    lr    = i0 ? last_rd0 : last_rd;
    e.err = (addr[1:0] != 2'b00);
    if (we) begin
      if (!e.err)
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
      e.rdata = lr;
    end else begin
      e.rdata = e.err ? 32'd0 : word;
      lr      = e.rdata;
    end
    if (i0) begin ref_mem0[idx] = word; last_rd0 = lr; end
    else    begin ref_mem[idx]  = word; last_rd  = lr; end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]  = '0;
      ref_mem0[i] = '0;
    end
    last_rd  = '0;
    last_rd0 = '0;
    q.delete();
    q0.delete();
  endtask

  task automatic garbage();
    bus.req   = 1'($urandom);
    bus.we    = 1'($urandom);
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    bus.be    = 4'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle, req low.
  task automatic do_txn(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.be = be;
    ref_apply(1'b0, we, addr, wdata, be, e);
    q.push_back(e);
    @(posedge clk);
    repeat (W) begin
      @(negedge clk);
      chk("wait_busy", bus.busy, 1);
      chk("wait_ready", bus.ready, 0);
      garbage();
      @(posedge clk);
    end
    @(negedge clk);
    chk("latency_ready", bus.ready, 1);
    garbage();
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_ready", bus.ready, 0);
    bus.req = 1'b0;
  endtask

  // Scoreboard monitor for the WAIT=2 instance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.ready === 1'b1) begin
      if (q.size() == 0) chk("spurious_ready", 1, 0);
      else begin
        e = q.pop_front();
        chk("rdata", bus.rdata, e.rdata);
        chk("err", bus.err, e.err);
      end
    end else if (reset === 1'b0) begin
      chk("err_outside_resp", bus.err, 0);
    end
  end

  // Scoreboard monitor for the WAIT=0 instance.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.ready === 1'b1) begin
      if (q0.size() == 0) chk("spurious_ready0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("rdata0", bus0.rdata, e.rdata);
        chk("err0", bus0.err, e.err);
      end
    end
  end

  initial begin
    logic        rwe;
    logic [31:0] raddr;
    exp_t        e;

    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;
    clear_ref();
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy0", bus0.busy, 0);
    reset = 1'b0;

    // Basic store/load, request in the first cycle after reset.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    do_txn(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("basic_load", bus.rdata, 32'hDEADBEEF);

    // Byte merge.
    do_txn(1'b1, 32'h10, 32'h11223344, 4'b0101);
    do_txn(1'b0, 32'h10, 32'h0, 4'b1111);
    chk("byte_merge", bus.rdata, 32'hDE22BE44);

    // Store with no byte enables changes nothing.
    do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    do_txn(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("be_zero", bus.rdata, 32'hDE22BE44);

    // Misaligned store writes nothing; misaligned load returns zero.
    do_txn(1'b1, 32'h13, 32'h55555555, 4'b1111);
    chk("mis_store_keeps_rdata", bus.rdata, 32'hDE22BE44);
    do_txn(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("mis_store_nowrite", bus.rdata, 32'hDE22BE44);
    do_txn(1'b0, 32'h12, 32'h0, 4'b0000);
    chk("mis_load_zero", bus.rdata, 32'h0);

    // Aliasing of upper address bits.
    do_txn(1'b1, 32'h1000, 32'hA5A5A5A5, 4'b1111);
    do_txn(1'b0, 32'h0, 32'h0, 4'b0000);
    chk("alias", bus.rdata, 32'hA5A5A5A5);

    // Reset during WAITING aborts the store and clears memory.
    do_txn(1'b1, 32'h20, 32'h12345678, 4'b1111);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hCAFEF00D; bus.be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.ready, 0);
    chk("abort_rdata", bus.rdata, 0);
    clear_ref();
    do_txn(1'b0, 32'h20, 32'h0, 4'b0000);
    chk("abort_mem_cleared", bus.rdata, 32'h0);

    // Random traffic over a small word set with random upper bits.
    for (int n = 0; n < 300; n++) begin
      rwe   = 1'($urandom);
      raddr = $urandom;
      raddr[11:2] = 10'($urandom_range(0, 15));
      raddr[1:0]  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(rwe, raddr, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WAIT=0 instance: req held high, a new request every second cycle.
    for (int k = 0; k < 24; k++) begin
      rwe   = (k < 4) ? 1'b1 : 1'($urandom);
      raddr = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 7) == 0) raddr[1:0] = 2'($urandom_range(1, 3));
      bus0.req = 1'b1; bus0.we = rwe; bus0.addr = raddr;
      bus0.wdata = $urandom; bus0.be = 4'($urandom);
      ref_apply(1'b1, rwe, raddr, bus0.wdata, bus0.be, e);
      q0.push_back(e);
      if (k > 0) chk("b2b_busy_low", bus0.busy, 0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ready", bus0.ready, 1);
      chk("b2b_busy_high", bus0.busy, 1);
      bus0.we = 1'($urandom); bus0.addr = $urandom;
      bus0.wdata = $urandom;  bus0.be = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    bus0.req = 1'b0;

    repeat (4) @(negedge clk);
    chk("q_drained", q.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
